// File: rtl/datagram_tx_pkg.sv
// datagram_tx_pkg: link constants, tx state type and serial CRC-8 step shared by the datagram link ends.
package datagram_tx_pkg;
    localparam int         MESSAGE_SIZE   = 16;
    localparam logic [7:0] LINK_SYNC_WORD = 8'hA5;
    localparam int         LINK_CLK_DIV   = 4;
    localparam int         LINK_GAP_BITS  = 2;
    localparam logic [7:0] CRC8_POLY      = 8'h07;

    typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, CRC, GAP} link_tx_state_e;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/link_crc8.sv
// link_crc8: serial CRC-8 (poly 0x07, init 0) with synchronous clear and per-bit enable.
module link_crc8
    import datagram_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);
    logic [7:0] crc_q;

    always_ff @(posedge clk) begin
        if (!rst || clr_i) crc_q <= '0;
        else if (en_i)     crc_q <= crc8_step(crc_q, bit_i);
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/datagram_tx.sv
// datagram_tx: serializes one datagram as sync word, LSB-first payload and gap on a source-synchronous link.
// Define DATAGRAM_TX_CRC_EN to append a CRC-8 over the payload before the gap.
module datagram_tx
    import datagram_tx_pkg::*;
#(
    parameter int         MSG_W     = MESSAGE_SIZE,
    parameter int         CLK_DIV   = LINK_CLK_DIV,
    parameter logic [7:0] SYNC_WORD = LINK_SYNC_WORD,
    parameter int         GAP_BITS  = LINK_GAP_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] datagram,
    input  logic             send_valid,
    output logic             send_ready,
    output logic             tx_data,
    output logic             tx_clk,
    output logic             tx_frame,
    output logic             busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(MSG_W + 1);

    link_tx_state_e   state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [MSG_W-1:0] sh_q, sh_d;
    logic             bit_end, crc_bit;

    assign bit_end = cyc_q == CW'(CLK_DIV - 1);

`ifdef DATAGRAM_TX_CRC_EN
    logic [7:0] crc;

    link_crc8 u_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == IDLE),
        .en_i  (state_q == PAYLOAD && bit_end),
        .bit_i (sh_q[0]),
        .crc_o (crc)
    );

    assign crc_bit = crc[bit_q[2:0]];
`else
    assign crc_bit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // bit_q counts down the bits of the current state and is reloaded on every state change
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (state_q == IDLE) begin
            if (send_valid) begin
                state_d = SYNC;
                bit_d   = BW'(7);
                sh_d    = datagram;
            end
        end else begin
            cyc_d = bit_end ? '0 : cyc_q + CW'(1);
            if (bit_end) begin
                bit_d = bit_q - BW'(1);
                if (state_q == PAYLOAD) sh_d = sh_q >> 1;
                if (bit_q == '0) begin
                    case (state_q)
                        SYNC: begin
                            state_d = PAYLOAD;
                            bit_d   = BW'(MSG_W - 1);
                        end
`ifdef DATAGRAM_TX_CRC_EN
                        PAYLOAD: begin
                            state_d = CRC;
                            bit_d   = BW'(7);
                        end
                        CRC: begin
                            state_d = GAP;
                            bit_d   = BW'(GAP_BITS - 1);
                        end
`else
                        PAYLOAD: begin
                            state_d = GAP;
                            bit_d   = BW'(GAP_BITS - 1);
                        end
`endif
                        default: begin
                            state_d = IDLE;
                            bit_d   = '0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        send_ready = state_q == IDLE;
        busy       = state_q != IDLE;
        tx_frame   = state_q == SYNC || state_q == PAYLOAD || state_q == CRC;
        tx_clk     = tx_frame && cyc_q >= CW'(CLK_DIV / 2);
        tx_data    = (state_q == SYNC)    ? SYNC_WORD[bit_q[2:0]] :
                     (state_q == PAYLOAD) ? sh_q[0] :
                     (state_q == CRC)     ? crc_bit : 1'b1;
    end
endmodule

// File: tb/tb_datagram_tx.sv
// tb_datagram_tx: randomized self-checking bench for datagram_tx against a frame-level reference model.
module tb_datagram_tx;
    localparam int MSG_W   = 16;
    localparam int CLK_DIV = 4;
    localparam int GAP     = 2;
`ifdef DATAGRAM_TX_CRC_EN
    localparam int FB = 32;
`else
    localparam int FB = 24;
`endif

    logic        clk = 0;
    logic        rst = 0;
    logic [15:0] datagram = '0;
    logic        send_valid = 0;
    logic        send_ready, tx_data, tx_clk, tx_frame, busy;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] rx_word = '0;
    int          rx_n = 0;
    int          frame_cycles = 0;
    logic        prev_frame = 0;
    logic        prev_clk = 0;

    datagram_tx #(.MSG_W(MSG_W), .CLK_DIV(CLK_DIV), .SYNC_WORD(8'hA5), .GAP_BITS(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .datagram   (datagram),
        .send_valid (send_valid),
        .send_ready (send_ready),
        .tx_data    (tx_data),
        .tx_clk     (tx_clk),
        .tx_frame   (tx_frame),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // receiver-side view: bits captured on tx_clk rising edges while tx_frame is high
    always @(negedge clk) begin
        if (tx_frame && !prev_frame) begin
            rx_word = '0;
            rx_n = 0;
            frame_cycles = 0;
        end
        if (tx_frame) frame_cycles++;
        if (tx_frame && tx_clk && !prev_clk) begin
            rx_word = {rx_word[30:0], tx_data};
            rx_n++;
        end
        prev_frame = tx_frame;
        prev_clk = tx_clk;
    end

    // whole frame as a bit string, first transmitted bit most significant
    function automatic logic [31:0] model(input logic [15:0] d);
        logic [31:0] w = 32'hA5;
        logic [7:0]  c = 8'h00;
        logic        fb;
        for (int i = 0; i < 16; i++) begin
            w = {w[30:0], d[i]};
            fb = c[7] ^ d[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
`ifdef DATAGRAM_TX_CRC_EN
        w = {w[23:0], c};
`endif
        return w;
    endfunction

    task automatic send(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!send_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!send_ready) $display("FAIL send_wait: send_ready=%b required 1", send_ready);
        else passed++;
        datagram = d;
        send_valid = 1;
        @(posedge clk);
        #1 send_valid = 0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (tx_frame && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_frame) $display("FAIL frame_end_timeout: tx_frame=%b required 0", tx_frame);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (send_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", send_ready); else passed++;
        if (tx_data !== 1'b1) $display("FAIL reset_data: got %b want 1", tx_data); else passed++;
        if (tx_frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", tx_frame); else passed++;
        if (tx_clk !== 1'b0) $display("FAIL reset_clk: got %b want 0", tx_clk); else passed++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst = 1;
    endtask

    task automatic test_single();
        int cnt;
        send(16'h1234);
        checks += 5;
        if (tx_frame !== 1'b1) $display("FAIL start_frame: got %b want 1", tx_frame); else passed++;
        if (tx_data !== 1'b1) $display("FAIL start_data: got %b want 1", tx_data); else passed++;
        if (send_ready !== 1'b0) $display("FAIL start_ready: got %b want 0", send_ready); else passed++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else passed++;
        if (tx_clk !== 1'b0) $display("FAIL start_clk: got %b want 0", tx_clk); else passed++;
        @(negedge clk);
        wait_end();
        checks += 8;
        if (rx_word[FB-1 -: 24] !== 24'hA52C48) $display("FAIL single_bits: got %h want a52c48", rx_word[FB-1 -: 24]); else passed++;
        if (rx_word !== model(16'h1234)) $display("FAIL single_word: got %h want %h", rx_word, model(16'h1234)); else passed++;
        if (rx_n !== FB) $display("FAIL single_nbits: got %0d want %0d", rx_n, FB); else passed++;
        if (frame_cycles !== FB * CLK_DIV) $display("FAIL single_len: got %0d want %0d", frame_cycles, FB * CLK_DIV); else passed++;
        if (tx_data !== 1'b1) $display("FAIL gap_data: got %b want 1", tx_data); else passed++;
        if (tx_clk !== 1'b0) $display("FAIL gap_clk: got %b want 0", tx_clk); else passed++;
        if (busy !== 1'b1) $display("FAIL gap_busy: got %b want 1", busy); else passed++;
        if (send_ready !== 1'b0) $display("FAIL gap_ready: got %b want 0", send_ready); else passed++;
        cnt = 1;
        while (!send_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== GAP * CLK_DIV + 1) $display("FAIL ready_return: got %0d want %0d", cnt, GAP * CLK_DIV + 1); else passed++;
    endtask

    task automatic test_crc();
`ifdef DATAGRAM_TX_CRC_EN
        send(16'h0001);
        wait_end();
        checks += 2;
        if (rx_word[7:0] !== 8'hB6) $display("FAIL crc_bits: got %h want b6", rx_word[7:0]); else passed++;
        if (frame_cycles !== 128) $display("FAIL crc_len: got %0d want 128", frame_cycles); else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int n = 0;
        @(negedge clk);
        datagram = 16'hAAAA;
        send_valid = 1;
        while (!(send_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 datagram = 16'h5555;
        @(negedge clk);
        wait_end();
        checks++;
        if (rx_word !== model(16'hAAAA)) $display("FAIL b2b_first: got %h want %h", rx_word, model(16'hAAAA)); else passed++;
        while (!tx_frame && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        send_valid = 0;
        checks++;
        if (cnt !== GAP * CLK_DIV + 1) $display("FAIL b2b_gap: got %0d want %0d", cnt, GAP * CLK_DIV + 1); else passed++;
        wait_end();
        checks++;
        if (rx_word !== model(16'h5555)) $display("FAIL b2b_second: got %h want %h", rx_word, model(16'h5555)); else passed++;
    endtask

    task automatic test_snapshot();
        send(16'hFFFF);
        @(posedge clk);
        #1 datagram = 16'h0000;
        @(negedge clk);
        wait_end();
        checks++;
        if (rx_word !== model(16'hFFFF)) $display("FAIL snapshot: got %h want %h", rx_word, model(16'hFFFF)); else passed++;
    endtask

    task automatic test_abort();
        logic [15:0] d = 16'($urandom);
        int n = 0;
        send(d);
        while (rx_n < 13 && n < 400) begin
            @(negedge clk);
            n++;
        end
        rst = 0;
        @(posedge clk);
        #1;
        checks += 5;
        if (tx_frame !== 1'b0) $display("FAIL abort_frame: got %b want 0", tx_frame); else passed++;
        if (tx_data !== 1'b1) $display("FAIL abort_data: got %b want 1", tx_data); else passed++;
        if (send_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", send_ready); else passed++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        if (tx_clk !== 1'b0) $display("FAIL abort_clk: got %b want 0", tx_clk); else passed++;
        @(negedge clk);
        rst = 1;
        d = 16'($urandom);
        send(d);
        @(negedge clk);
        wait_end();
        checks++;
        if (rx_word !== model(d)) $display("FAIL abort_resend: got %h want %h", rx_word, model(d)); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            send(d);
            @(negedge clk);
            wait_end();
            checks += 2;
            if (rx_word !== model(d)) $display("FAIL random_word[%0d]: got %h want %h", i, rx_word, model(d)); else passed++;
            if (frame_cycles !== FB * CLK_DIV) $display("FAIL random_len[%0d]: got %0d want %0d", i, frame_cycles, FB * CLK_DIV); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_crc();
        test_back_to_back();
        test_snapshot();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/datagram_tx.md
Name: datagram_tx

Overview:
- Transmitting end of the core→display datagram link: serializes one MESSAGE_SIZE-bit datagram into a framed, source-synchronous bit stream.
- A per-quadrant receiver rebuilds the parallel datagram that feeds each display's output interface.
- Sits in the game core, one instance per display link.
- Accepts a datagram on a valid/ready handshake, snapshots it, then transmits: sync word, payload, optional CRC, inter-frame gap.

Parameters:
- MSG_W, MESSAGE_SIZE, payload width in bits.
- CLK_DIV, 4, clk cycles per link bit; must be even and ≥2.
- SYNC_WORD, 8'hA5, frame sync pattern, sent MSB first.
- GAP_BITS, 2, idle bit periods after each frame; ≥1.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, synchronous, active-low.
- datagram  input  MSG_W  payload; sampled only on acceptance.
- send_valid  input  1  a datagram is offered.
- send_ready  output  1  block can accept; high only in IDLE.
- tx_data  output  1  serial data line; idles high.
- tx_clk  output  1  link bit clock; receiver samples on its rising edge.
- tx_frame  output  1  high from the first sync bit to the last payload/CRC bit.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst (rst==0 at a posedge resets).
- Reset values: send_ready=1, tx_data=1, tx_clk=0, tx_frame=0, busy=0, state=IDLE, all counters 0.
- Acceptance: send_valid && send_ready at posedge N.
  - datagram is latched into the shift register.
  - At N+1: state=SYNC, send_ready=0, busy=1, tx_frame=1, tx_data = SYNC_WORD[7].
- Datagram changes after acceptance have no effect on the frame in flight.
- States: IDLE → SYNC (8 bits) → PAYLOAD (MSG_W bits) → CRC (8 bits, only with the optional feature) → GAP (GAP_BITS bits) → IDLE.
- Bit timing:
  - Each bit is held on tx_data for exactly CLK_DIV cycles.
  - tx_clk is 0 for the first CLK_DIV/2 cycles of the bit period and 1 for the second half. The rising edge is mid-bit.
  - tx_data changes only at bit-period boundaries.
- Bit order: sync MSB first; payload LSB first (datagram[0] first, matching the receiver's core_state-in-low-bits layout); CRC MSB first.
- GAP: tx_data=1, tx_frame=0, tx_clk held 0, busy=1, send_ready=0.
- GAP exit: on the last cycle of GAP the state moves to IDLE, so send_ready=1 on the following cycle.
  - Continuously asserted send_valid yields back-to-back frames with exactly GAP_BITS*CLK_DIV + 1 non-frame cycles between them.
- Counters:
  - Cycle counter width is $clog2(CLK_DIV).
  - Bit counter width is $clog2(MSG_W+1). It counts down to 0 and reloads at each state change; there is no wrap-around within a state.
- Reset mid-frame: the frame is aborted and all outputs return to reset values at the next edge; the receiver discards the frame because tx_frame drops early.
- Frame length in cycles, with the feature off: (8+MSG_W)*CLK_DIV.

Optional Feature:
- Macro: DATAGRAM_TX_CRC_EN.
- Defined:
  - CRC-8, polynomial 0x07, initial value 0x00, computed serially over payload bits in transmit order: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 0).
  - Appended in the CRC state, MSB first. tx_frame stays high through the CRC.
- Undefined: the CRC state and register are absent; PAYLOAD goes directly to GAP.

Decomposition:
- Shared package/header (constants.svh): MESSAGE_SIZE, LINK_SYNC_WORD, LINK_CLK_DIV, LINK_GAP_BITS, CRC8_POLY.
- Shared typedef: enum LinkTxState {IDLE, SYNC, PAYLOAD, CRC, GAP}, so the receiver can reuse the CRC constant.
- One sub-module: link_crc8 (serial CRC-8 update with clear/enable), reused unchanged by the receiver.

Test Plan:
- Bench setup for all cases: MSG_W=16, CLK_DIV=4, GAP_BITS=2.
- Reset: hold rst=0 for 3 cycles → send_ready=1, tx_data=1, tx_frame=0, tx_clk=0, busy=0.
- Single frame, feature off, datagram 16'h1234:
  - Sampled tx_data on tx_clk rising edges = 10100101 followed by 0010110001001000.
  - tx_frame high for 96 cycles; send_ready returns 9 cycles after tx_frame falls.
- Single frame, feature on, datagram 16'h0001 → CRC bits 10110110 (8'hB6); tx_frame high for 128 cycles.
- Back-to-back: send_valid held high with datagrams 16'hAAAA then 16'h5555 → two intact frames, exactly 9 non-frame cycles between them, second payload 16'h5555.
- Snapshot: change datagram from 16'hFFFF to 16'h0000 one cycle after acceptance → transmitted payload is all ones.
- Abort: drive rst=0 at payload bit 5 → next cycle tx_frame=0, tx_data=1, send_ready=1. A new send after reset starts with a clean sync word.
